// File: rtl/sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// sprite_addr_gen : priority sprite hit test, ROM address and frame sequencer
// Revision: 1.0
// ============================================================================
module sprite_addr_gen #(
  parameter  int N_SPRITES = 4,
  parameter  int COORD_W   = 10,
  parameter  int ADDR_W    = 20,
  parameter  int FRAME_W   = 4,
  parameter  int ANIM_DIV  = 8,
  localparam int ID_W      = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic                           frame_Clk,
  input  logic                           Reset,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic                           vsync_tick,
  input  logic [N_SPRITES-1:0]           anim_enable,
  input  logic [N_SPRITES-1:0]           anim_restart,
  input  logic [N_SPRITES-1:0]           sprite_flip,
  input  logic [N_SPRITES*COORD_W-1:0]   sprite_X,
  input  logic [N_SPRITES*COORD_W-1:0]   sprite_Y,
  input  logic [N_SPRITES*COORD_W-1:0]   sprite_W,
  input  logic [N_SPRITES*COORD_W-1:0]   sprite_H,
  input  logic [N_SPRITES*ADDR_W-1:0]    base_addr,
  input  logic [N_SPRITES*FRAME_W-1:0]   frame_count,
  output logic                           sprite_on,
  output logic [ID_W-1:0]                sprite_id,
  output logic [ADDR_W-1:0]              spriteAddress,
  output logic [N_SPRITES*FRAME_W-1:0]   frame_idx
);

  localparam int                DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(ANIM_DIV - 1);

  logic [N_SPRITES-1:0] hit;
  logic [ADDR_W-1:0]    chan_addr [N_SPRITES];
  logic [DIV_W-1:0]     div_cnt;
  logic                 advance;
  logic                 any_hit;
  logic [ID_W-1:0]      win_id;
  logic [ADDR_W-1:0]    win_addr;

  assign advance = vsync_tick && (div_cnt == DIV_LAST);

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      div_cnt <= '0;
    end else if (vsync_tick) begin
      div_cnt <= advance ? '0 : div_cnt + DIV_W'(1);
    end
  end

  for (genvar i = 0; i < N_SPRITES; i++) begin : g_chan
    logic [COORD_W-1:0] x, y, w, h, dx, dy, col;
    logic [COORD_W:0]   x_end, y_end;
    logic [ADDR_W-1:0]  base;
    logic [FRAME_W-1:0] count, eff_count, frame_q;
    logic [FRAME_W:0]   frame_inc;

    assign x     = sprite_X[i*COORD_W +: COORD_W];
    assign y     = sprite_Y[i*COORD_W +: COORD_W];
    assign w     = sprite_W[i*COORD_W +: COORD_W];
    assign h     = sprite_H[i*COORD_W +: COORD_W];
    assign base  = base_addr[i*ADDR_W +: ADDR_W];
    assign count = frame_count[i*FRAME_W +: FRAME_W];

    // One extra bit on the far edges so sprites touching column/row 1023 do not wrap
    assign x_end = {1'b0, x} + {1'b0, w};
    assign y_end = {1'b0, y} + {1'b0, h};

    assign hit[i] = (w != '0) && (h != '0) &&
                    (DrawX >= x) && ({1'b0, DrawX} < x_end) &&
                    (DrawY >= y) && ({1'b0, DrawY} < y_end);

    assign dx  = DrawX - x;
    assign dy  = DrawY - y;
    assign col = sprite_flip[i] ? (w - COORD_W'(1) - dx) : dx;

    assign chan_addr[i] = base
                        + ADDR_W'(frame_q) * ADDR_W'(w) * ADDR_W'(h)
                        + ADDR_W'(dy) * ADDR_W'(w)
                        + ADDR_W'(col);

    assign eff_count = (count == '0) ? FRAME_W'(1) : count;
    assign frame_inc = {1'b0, frame_q} + (FRAME_W+1)'(1);

    // A shrunken frame_count leaves the index alone until the next advance wraps it
    always_ff @(posedge frame_Clk) begin
      if (Reset || anim_restart[i]) begin
        frame_q <= '0;
      end else if (advance && anim_enable[i]) begin
        frame_q <= (frame_inc >= {1'b0, eff_count}) ? '0 : frame_inc[FRAME_W-1:0];
      end
    end

    assign frame_idx[i*FRAME_W +: FRAME_W] = frame_q;
  end

  always_comb begin
    any_hit  = 1'b0;
    win_id   = '0;
    win_addr = '0;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        win_id   = ID_W'(i);
        win_addr = chan_addr[i];
      end
    end
  end

  // Id and address hold on a miss so the ROM input stays stable
  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      sprite_on     <= 1'b0;
      sprite_id     <= '0;
      spriteAddress <= '0;
    end else begin
      sprite_on <= any_hit;
      if (any_hit) begin
        sprite_id     <= win_id;
        spriteAddress <= win_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_addr_gen.sv
`default_nettype none
// ============================================================================
// tb_sprite_addr_gen : scoreboard bench with directed and random stimulus
// Revision: 1.0
// ============================================================================
module tb_sprite_addr_gen;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int AW = 20;
  localparam int FW = 4;
  localparam int AD = 8;

  logic          clk, rst;
  logic [CW-1:0] draw_x, draw_y;
  logic          vsync;
  logic [N-1:0]  en, restart, flip;
  logic [N*CW-1:0] sx, sy, sw, sh;
  logic [N*AW-1:0] base;
  logic [N*FW-1:0] fc;
  logic          on;
  logic [1:0]    id;
  logic [AW-1:0] addr;
  logic [N*FW-1:0] fidx;

  sprite_addr_gen #(.N_SPRITES(N), .COORD_W(CW), .ADDR_W(AW), .FRAME_W(FW), .ANIM_DIV(AD)) dut (
    .frame_Clk(clk), .Reset(rst), .DrawX(draw_x), .DrawY(draw_y),
    .vsync_tick(vsync), .anim_enable(en), .anim_restart(restart), .sprite_flip(flip),
    .sprite_X(sx), .sprite_Y(sy), .sprite_W(sw), .sprite_H(sh),
    .base_addr(base), .frame_count(fc),
    .sprite_on(on), .sprite_id(id), .spriteAddress(addr), .frame_idx(fidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          on;
    logic [1:0]    id;
    logic [AW-1:0] addr;
    logic [N*FW-1:0] fr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // reference model state
  int mframe[N];
  int mdiv;
  int hold_id, hold_addr;

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic int gx(int i); return int'(sx[i*CW +: CW]); endfunction
  function automatic int gy(int i); return int'(sy[i*CW +: CW]); endfunction
  function automatic int gw(int i); return int'(sw[i*CW +: CW]); endfunction
  function automatic int gh(int i); return int'(sh[i*CW +: CW]); endfunction
  function automatic longint gb(int i); return longint'(base[i*AW +: AW]); endfunction
  function automatic int gf(int i); return int'(fc[i*FW +: FW]); endfunction

  task automatic setch(input int i, input int x, input int y, input int w, input int h,
                       input int b, input int cnt);
    sx[i*CW +: CW]   = CW'(x);
    sy[i*CW +: CW]   = CW'(y);
    sw[i*CW +: CW]   = CW'(w);
    sh[i*CW +: CW]   = CW'(h);
    base[i*AW +: AW] = AW'(b);
    fc[i*FW +: FW]   = FW'(cnt);
  endtask

  // Predict the outcome of the coming edge, queue it, then clock once.
  task automatic step();
    exp_t e;
    bit found, adv;
    int px, py, x, y, w, h, col, eff;
    longint a;
    px = int'(draw_x);
    py = int'(draw_y);
    found = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) mframe[i] = 0;
      mdiv = 0; hold_id = 0; hold_addr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        x = gx(i); y = gy(i); w = gw(i); h = gh(i);
        if (!found && w > 0 && h > 0 && px >= x && px < x + w && py >= y && py < y + h) begin
          found = 1;
          col = flip[i] ? (w - 1 - (px - x)) : (px - x);
          a = gb(i) + longint'(mframe[i]) * w * h + longint'(py - y) * w + col;
          hold_id   = i;
          hold_addr = int'(a % (64'd1 << AW));
        end
      end
      adv = 0;
      if (vsync) begin
        adv  = (mdiv == AD - 1);
        mdiv = (mdiv + 1) % AD;
      end
      for (int i = 0; i < N; i++) begin
        eff = (gf(i) == 0) ? 1 : gf(i);
        if (restart[i]) mframe[i] = 0;
        else if (adv && en[i]) mframe[i] = (mframe[i] + 1 >= eff) ? 0 : mframe[i] + 1;
      end
    end
    e.on   = found;
    e.id   = 2'(hold_id);
    e.addr = AW'(hold_addr);
    for (int i = 0; i < N; i++) e.fr[i*FW +: FW] = FW'(mframe[i]);
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      vsync = 1'b1; step();
      vsync = 1'b0; step();
    end
  endtask

  // monitor: one registered result per clock
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_on", longint'(on), longint'(e.on));
      chk("sb_id", longint'(id), longint'(e.id));
      chk("sb_addr", longint'(addr), longint'(e.addr));
      for (int i = 0; i < N; i++)
        chk($sformatf("sb_frame%0d", i), longint'(fidx[i*FW +: FW]), longint'(e.fr[i*FW +: FW]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c, px, py;
    rst = 1'b1; draw_x = '0; draw_y = '0; vsync = 1'b0;
    en = '0; restart = '0; flip = '0;
    sx = '0; sy = '0; sw = '0; sh = '0; base = '0; fc = '0;
    @(negedge clk);
    step(); step();
    chk("rst_on", on, 0); chk("rst_addr", addr, 0); chk("rst_frames", fidx, 0);
    rst = 1'b0;

    // single channel, no flip
    setch(0, 100, 50, 24, 45, 0, 1);
    draw_x = 100; draw_y = 50; step();
    chk("tp_on0", on, 1); chk("tp_id0", id, 0); chk("tp_addr0", addr, 0);
    draw_x = 123; draw_y = 94; step();
    chk("tp_addr_corner", addr, 1079);
    draw_x = 124; step();
    chk("tp_miss_on", on, 0); chk("tp_miss_hold", addr, 1079);

    // flipped
    flip[0] = 1'b1; setch(0, 100, 50, 24, 45, 20736, 1);
    draw_x = 100; draw_y = 50; step();
    chk("tp_flip_left", addr, 20759);
    draw_x = 123; step();
    chk("tp_flip_right", addr, 20736);
    flip[0] = 1'b0;

    // overlap
    setch(0, 190, 190, 24, 45, 0, 1);
    setch(2, 195, 195, 10, 10, 5000, 1);
    draw_x = 200; draw_y = 200; step();
    chk("tp_ovl_id", id, 0); chk("tp_ovl_addr", addr, 250);
    setch(0, 190, 190, 0, 45, 0, 1); step();
    chk("tp_ovl2_id", id, 2); chk("tp_ovl2_addr", addr, 5055);
    setch(2, 0, 0, 0, 0, 0, 1);

    // animation
    setch(0, 100, 50, 24, 45, 0, 3);
    setch(1, 0, 0, 0, 0, 0, 3);
    en = 4'b0011; draw_x = 0; draw_y = 0;
    pulses(8);
    chk("tp_anim_f1", fidx[3:0], 1);
    draw_x = 100; draw_y = 50; step();
    chk("tp_anim_addr", addr, 1080);
    draw_x = 0; draw_y = 0;
    pulses(16);
    chk("tp_anim_wrap", fidx[3:0], 0);

    // restart beats advance; disabled channel holds
    pulses(8);
    en[1] = 1'b0;
    pulses(7);
    vsync = 1'b1; restart[0] = 1'b1; step();
    vsync = 1'b0; restart[0] = 1'b0; step();
    chk("tp_restart", fidx[3:0], 0); chk("tp_disabled_hold", fidx[7:4], 1);

    // reset mid-animation with a hit showing
    en[0] = 1'b1;
    pulses(16);
    pulses(3);
    draw_x = 100; draw_y = 50; step();
    chk("tp_pre_rst_on", on, 1); chk("tp_pre_rst_f2", fidx[3:0], 2); chk("tp_pre_rst_addr", addr, 2160);
    rst = 1'b1; step(); rst = 1'b0;
    chk("tp_rst_on", on, 0); chk("tp_rst_id", id, 0); chk("tp_rst_addr", addr, 0); chk("tp_rst_frames", fidx, 0);
    draw_x = 0; draw_y = 0;
    pulses(7);
    chk("tp_div_cleared", fidx[3:0], 0);
    pulses(1);
    chk("tp_div_resume", fidx[3:0], 1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 0 || $urandom_range(0, 39) == 0) begin
        for (int i = 0; i < N; i++)
          setch(i,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 100)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 100)),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60)),
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60)),
                int'($urandom & 32'hFFFFF), int'($urandom_range(0, 6)));
        flip = 4'($urandom);
        en   = 4'($urandom);
      end
      c  = int'($urandom_range(0, N - 1));
      px = gx(c) + int'($urandom_range(0, gw(c) + 3)) - 2;
      py = gy(c) + int'($urandom_range(0, gh(c) + 3)) - 2;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      draw_x = CW'(px); draw_y = CW'(py);
      vsync = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) restart[i] = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; vsync = 1'b0; restart = '0;
    step();
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
